// File: rtl/fp_pkg.sv
// Shared types and constants for the fp_adder issue path.
// Holds the request layout, flag bit positions and canonical NaN patterns.
package fp_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
  localparam logic [15:0] QNAN_HP = 16'h7E00;

  localparam logic MODE_SINGLE = 1'b1;
  localparam logic MODE_HALF   = 1'b0;

  localparam int REQ_W = 67;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        mode_fp;
    logic        round_mode;
  } fp_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  // Half-precision operands live in [15:0]; anything above is zeroed.
  function automatic fp_req_t mask_half(input fp_req_t r);
    fp_req_t m;
    m = r;
    if (r.mode_fp == MODE_HALF) begin
      m.a[31:16] = 16'h0000;
      m.b[31:16] = 16'h0000;
    end
    return m;
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request queue in front of the adder: DEPTH-entry synchronous FIFO with occupancy count.
// Pushes into a full queue and pops from an empty queue are dropped.
module fp_req_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REQ_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != CNT_FULL);
  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Issue stage for fp_adder: queues add/sub requests, runs one at a time through the
// adder handshake, returns results on a valid/ready port and keeps sticky flags plus a watchdog.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic                     req_sub,
  input  logic                     req_mode_fp,
  input  logic                     req_round_mode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [4:0]               rsp_flags,
  output logic [4:0]               sticky_flags,
  input  logic                     flags_clr,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   req_count,
  output logic                     fpa_start,
  output logic                     fpa_sub,
  output logic                     fpa_mode_fp,
  output logic                     fpa_round_mode,
  output logic [31:0]              fpa_op_a,
  output logic [31:0]              fpa_op_b,
  output logic                     fpa_ready_in,
  input  logic                     fpa_valid_out,
  input  logic                     fpa_ready_out,
  input  logic [31:0]              fpa_result,
  input  logic [4:0]               fpa_flags
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [4:0]     NV_ONLY  = 5'(1 << FLAG_NV);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  fp_req_t          w_req_in;
  fp_req_t          w_head;
  fp_req_t          r_req;
  logic [REQ_W-1:0] w_head_bits;
  logic [CW-1:0]    w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_timeout_hit;
  logic             w_handshake;
  logic [WDW-1:0]   r_wd;
  logic [31:0]      r_rsp_result;
  logic [4:0]       r_rsp_flags;
  logic [4:0]       r_sticky;
  logic             r_timeout;

  assign w_req_in  = {req_a, req_b, req_sub, req_mode_fp, req_round_mode};
  assign w_head    = w_head_bits;
  assign req_ready = !rst && (w_count != CNT_FULL);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == ST_IDLE) && (w_count != '0) && fpa_ready_out;

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_req_in),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A valid_out in the same cycle as the last watchdog tick wins over the timeout.
  always_comb begin
    w_next_state  = r_state;
    w_timeout_hit = 1'b0;
    w_handshake   = 1'b0;
    fpa_start     = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fpa_start    = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (fpa_valid_out) begin
          w_next_state = ST_RESP;
        end else if (r_wd == WD_LAST) begin
          w_timeout_hit = 1'b1;
          w_next_state  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_handshake  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req        <= '0;
      r_wd         <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_sticky     <= '0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_req <= mask_half(w_head);
      end

      if (r_state == ST_ISSUE) begin
        r_wd <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end

      if ((r_state == ST_WAIT) && fpa_valid_out) begin
        r_rsp_result <= (r_req.mode_fp == MODE_SINGLE) ? fpa_result
                                                        : {16'h0000, fpa_result[15:0]};
        r_rsp_flags  <= fpa_flags;
      end else if (w_timeout_hit) begin
        r_rsp_result <= (r_req.mode_fp == MODE_SINGLE) ? QNAN_SP : {16'h0000, QNAN_HP};
        r_rsp_flags  <= NV_ONLY;
      end

      // A clear coinciding with a delivery leaves exactly the delivered flags.
      if (w_handshake) begin
        r_sticky <= (flags_clr ? 5'b00000 : r_sticky) | r_rsp_flags;
      end else if (flags_clr) begin
        r_sticky <= '0;
      end

      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end else if (flags_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign rsp_result     = r_rsp_result;
  assign rsp_flags      = r_rsp_flags;
  assign sticky_flags   = r_sticky;
  assign timeout_err    = r_timeout;
  assign req_count      = w_count;
  assign fpa_op_a       = r_req.a;
  assign fpa_op_b       = r_req.b;
  assign fpa_sub        = r_req.sub;
  assign fpa_mode_fp    = r_req.mode_fp;
  assign fpa_round_mode = r_req.round_mode;
  assign fpa_ready_in   = !rst;

endmodule
